sha256_round_ctrl: RTL
======================

// Module: sha256_round_ctrl
// PURPOSE
//  Sequencer for the SHA-256 compression datapath. Accepts 512-bit blocks by valid/ready handshake.
//  Strobes block load, hash init, working-register load, 64 round enables and the final H += a..h add.
//  Presents digest_valid after the last block of a message. Sits between the padder and the round/schedule datapath.
// PARAMETERS
//  NUM_ROUNDS   64  compression rounds per block
//  SCHED_WORDS  16  rounds that take W directly from the block; later rounds use schedule expansion
//  IDX_W        6   width of round_idx; must satisfy 2**IDX_W >= NUM_ROUNDS
// PORTS
//  clk           in   1      clock; all logic on rising edge
//  rst           in   1      synchronous, active-high reset
//  abort         in   1      synchronous cancel of the current message
//  blk_valid     in   1      padder offers a block
//  blk_first     in   1      offered block is the first of a message; qualified by blk_valid
//  blk_last      in   1      offered block is the last of a message; qualified by blk_valid
//  blk_ready     out  1      controller can accept a block
//  load_block    out  1      datapath captures 512-bit block into the W registers
//  init_hash     out  1      datapath loads H0..H7 with the IV
//  load_working  out  1      datapath loads a..h from H0..H7
//  round_en      out  1      datapath executes one round
//  round_idx     out  IDX_W  current round t; selects K[t]
//  w_sel         out  1      0: W[t] from block words; 1: expanded schedule word
//  final_add     out  1      datapath performs H[i] += working[i]
//  digest_valid  out  1      H0..H7 hold the final digest
//  digest_ack    in   1      consumer has taken the digest
//  busy          out  1      high in every state except IDLE
// BEHAVIOUR
//  - States: IDLE, LOADW, ROUND, FINAL, DONE. All outputs decode from the registered state and counter.
//  - Reset: state=IDLE, round counter=0, chain_valid=0, first/last latches=0.
//    All strobes, digest_valid and busy are 0. blk_ready=0 while rst=1 and 1 from the first cycle after rst=0.
//  - Reset mid-operation: the next edge returns to IDLE. No final_add and no digest_valid are issued.
//  - IDLE: blk_ready=1. An accept is blk_valid&blk_ready&!abort.
//    On accept: load_block=1 in the same cycle (combinational); latch blk_last; next state LOADW.
//    init_hash=accept&(blk_first|!chain_valid). A non-first block with no chain in progress starts a new chain.
//  - LOADW: load_working=1 for exactly one cycle; counter=0; next state ROUND.
//  - ROUND: round_en=1 and round_idx=counter, which steps 0..NUM_ROUNDS-1 by one per cycle.
//    w_sel=(round_idx>=SCHED_WORDS). At round_idx==NUM_ROUNDS-1 the counter wraps to 0; next state FINAL.
//  - FINAL: final_add=1 for one cycle.
//    If last latched: chain_valid<=0; next state DONE. Otherwise chain_valid<=1; next state IDLE.
//  - DONE: digest_valid=1, held until digest_ack. digest_ack in the first DONE cycle is legal.
//    The cycle after ack the state is IDLE. digest_ack outside DONE is ignored.
//  - Latency: accept at cycle 0, load_working at 1, rounds at 2..NUM_ROUNDS+1, final_add at NUM_ROUNDS+2.
//    digest_valid from NUM_ROUNDS+3 (67 with defaults). A non-last block gives blk_ready again at NUM_ROUNDS+3.
//  - abort, any state: next state IDLE; counter=0; chain_valid=0; no final_add and no digest_valid.
//    abort in IDLE with blk_valid: abort wins, so no accept and no load_block.
//  - blk_valid while blk_ready=0 is ignored. The padder must hold the block until it is accepted.
//  - Exactly one of load_block, load_working, round_en and final_add is high in any cycle, or none is.
// STRUCTURE
//  - sha256_pkg holds: the state typedef enum logic [2:0] {IDLE,LOADW,ROUND,FINAL,DONE}.
//    It also holds NUM_ROUNDS/SCHED_WORDS defaults and the IV constant array (shared with the datapath).
//  - One sub-module, sha256_round_ctr: IDX_W-bit counter with sync clear, enable and a wrap flag.
//    The wrap flag is high when the count equals NUM_ROUNDS-1 and enable is set.
//  - Top: state register, next-state logic, chain_valid and last latches, output decode.
// TESTING
//  1 Single-block message (first=1,last=1) -> init_hash+load_block at c0, load_working at c1.
//    round_idx 0..63 on c2..c65, w_sel rises at round 16, final_add at c66, digest_valid at c67.
//  2 Two-block message -> init_hash only on block 1, no digest_valid after block 1.
//    blk_ready=1 at c67; block 2 goes through rounds; digest_valid after its FINAL.
//  3 digest_ack held high before DONE -> digest_valid high exactly 1 cycle, IDLE next.
//    Also: ack delayed 10 cycles -> digest_valid held 11 cycles and blk_ready stays 0 throughout.
//  4 abort at round_idx=30 -> IDLE next cycle, no final_add.
//    A following block with first=0 still asserts init_hash because chain_valid was cleared.
//  5 rst pulsed at round_idx=50 -> after release all strobes=0, blk_ready=1, round_idx=0, busy=0.
//  6 abort and blk_valid together in IDLE -> no load_block; blk_valid alone next cycle -> accepted normally.
//    All runs: assert one-hot-or-zero on the four strobes every cycle.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, default round geometry, initial hash value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sha256_pkg;

  localparam int NUM_ROUNDS_DEF  = 64;
  localparam int SCHED_WORDS_DEF = 16;
  localparam int IDX_W_DEF       = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOADW,
    ROUND,
    FINAL,
    DONE
  } state_t;

  // H0..H7 initial values, index 0 is H0; consumed by the datapath on init_hash
  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_ctr.sv
// Round counter: steps 0..NUM_ROUNDS-1 while enabled, wraps to 0, flags the last round.
// Latency: count updates one cycle after en; wrap is combinational from count and en.
// Backpressure: none; clr dominates en.
module sha256_round_ctr #(
  parameter int NUM_ROUNDS = 64,
  parameter int IDX_W      = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  assign wrap = en && (count == LAST_IDX);

  // count advances while enabled; the last round returns to zero for the next block
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: block accept, hash init, working load, 64 rounds, final add, digest hold.
// Latency: accept c0, load_working c1, rounds c2..c65, final_add c66, digest_valid/blk_ready from c67.
// Backpressure: blk_ready only in IDLE; digest_valid held until digest_ack; abort cancels from any state.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
  parameter int SCHED_WORDS = SCHED_WORDS_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             blk_valid,
  input  logic             blk_first,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic             load_block,
  output logic             init_hash,
  output logic             load_working,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             w_sel,
  output logic             final_add,
  output logic             digest_valid,
  input  logic             digest_ack,
  output logic             busy
);

  localparam logic [IDX_W-1:0] SCHED_IDX = IDX_W'(SCHED_WORDS);

  state_t           state;
  logic             chain_valid;
  logic             last_q;
  logic             accept;
  logic             ctr_clr;
  logic             ctr_en;
  logic             ctr_wrap;
  logic [IDX_W-1:0] ctr_q;

  // abort beats a simultaneous offer, so a cancelled cycle never loads a block
  assign blk_ready    = (state == IDLE) && !rst;
  assign accept       = blk_valid && blk_ready && !abort;
  assign load_block   = accept;
  // a non-first block arriving with no chain in flight starts a fresh chain
  assign init_hash    = accept && (blk_first || !chain_valid);
  assign load_working = (state == LOADW);
  assign round_en     = (state == ROUND);
  assign round_idx    = ctr_q;
  assign w_sel        = round_en && (ctr_q >= SCHED_IDX);
  assign final_add    = (state == FINAL);
  assign digest_valid = (state == DONE);
  assign busy         = (state != IDLE);

  assign ctr_clr = rst || abort || load_working;
  assign ctr_en  = round_en;

  sha256_round_ctr #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (IDX_W)
  ) u_round_ctr (
    .clk   (clk),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .count (ctr_q),
    .wrap  (ctr_wrap)
  );

  // state sequencing plus the chain and last-block latches
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= IDLE;
      chain_valid <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_q <= blk_last;
            state  <= LOADW;
          end
        end
        LOADW: state <= ROUND;
        ROUND: begin
          if (ctr_wrap) state <= FINAL;
        end
        FINAL: begin
          if (last_q) begin
            chain_valid <= 1'b0;
            state       <= DONE;
          end else begin
            chain_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        DONE: begin
          if (digest_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
